// File: rtl/mcp4922_rx.sv
// ============================================================================
// Module   : mcp4922_rx
// Brief    : Oversampling receive-side model of the MCP4922 dual 12-bit SPI DAC.
//            Optional macro MCP4922_RX_LDAC_EN enables the ldac_n transfer strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcp4922_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        sdi,
  input  logic        ldac_n,
  output logic [11:0] out_a,
  output logic [11:0] out_b,
  output logic        shdn_n_a,
  output logic        shdn_n_b,
  output logic        gain1x_a,
  output logic        gain1x_b,
  output logic        frame_valid,
  output logic        frame_axis,
  output logic        frame_error
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_cs_d;
  logic                   r_sck_d;
  logic                   r_sdi_d;
  logic                   r_cs_fall;
  logic                   r_cs_rise;
  logic                   r_sck_rise;
  logic                   w_cs_s;
  logic                   w_sck_s;
  logic                   w_ldac_low;

  logic [0:0]  r_state;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_next;
  logic [15:0] r_shreg;
  logic [11:0] r_in_a_data;
  logic [11:0] r_in_b_data;
  logic        r_in_a_ga_n;
  logic        r_in_b_ga_n;
  logic        r_in_a_shdn_n;
  logic        r_in_b_shdn_n;

  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];

  // Synchronizers reset to 0 so a frame already in progress at reset release
  // produces no falling edge and is ignored until cs_n next falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs_sync  <= '0;
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_d     <= 1'b0;
      r_sck_d    <= 1'b0;
      r_sdi_d    <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_sck_rise <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_cs_d     <= w_cs_s;
      r_sck_d    <= w_sck_s;
      r_sdi_d    <= r_sdi_sync[SYNC_STAGES-1];
      r_cs_fall  <= r_cs_d & ~w_cs_s;
      r_cs_rise  <= ~r_cs_d & w_cs_s;
      r_sck_rise <= ~r_sck_d & w_sck_s;
    end
  end

`ifdef MCP4922_RX_LDAC_EN
  logic [SYNC_STAGES-1:0] r_ldac_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ldac_sync <= '0;
    end else begin
      r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], ldac_n};
    end
  end

  assign w_ldac_low = ~r_ldac_sync[SYNC_STAGES-1];
`else
  // Pin kept for compatibility; transfer is permanently enabled.
  assign w_ldac_low = 1'b1 | ~ldac_n;
`endif

  assign w_cnt_next = (r_cnt == 5'd17) ? 5'd17 : r_cnt + 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 5'd0;
      r_shreg       <= 16'h0000;
      r_in_a_data   <= 12'h000;
      r_in_b_data   <= 12'h000;
      r_in_a_ga_n   <= 1'b0;
      r_in_b_ga_n   <= 1'b0;
      r_in_a_shdn_n <= 1'b0;
      r_in_b_shdn_n <= 1'b0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      frame_axis    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cs_fall) begin
            r_state <= S_SHIFT;
            r_cnt   <= 5'd0;
            r_shreg <= 16'h0000;
          end
        end
        S_SHIFT: begin
          if (r_cs_rise) begin
            r_state <= S_IDLE;
            if (r_cnt == 5'd16) begin
              // bit14 (BUF) has no effect on this model
              frame_valid <= 1'b1;
              frame_axis  <= r_shreg[15];
              if (r_shreg[15]) begin
                r_in_b_data   <= r_shreg[11:0];
                r_in_b_ga_n   <= r_shreg[13];
                r_in_b_shdn_n <= r_shreg[12];
              end else begin
                r_in_a_data   <= r_shreg[11:0];
                r_in_a_ga_n   <= r_shreg[13];
                r_in_a_shdn_n <= r_shreg[12];
              end
            end else begin
              frame_error <= 1'b1;
            end
          end else if (r_sck_rise) begin
            r_shreg <= {r_shreg[14:0], r_sdi_d};
            r_cnt   <= w_cnt_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_a    <= 12'h000;
      out_b    <= 12'h000;
      shdn_n_a <= 1'b0;
      shdn_n_b <= 1'b0;
      gain1x_a <= 1'b0;
      gain1x_b <= 1'b0;
    end else if (w_ldac_low) begin
      out_a    <= r_in_a_data;
      out_b    <= r_in_b_data;
      shdn_n_a <= r_in_a_shdn_n;
      shdn_n_b <= r_in_b_shdn_n;
      gain1x_a <= r_in_a_ga_n;
      gain1x_b <= r_in_b_ga_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcp4922_rx.sv
// ============================================================================
// Module   : tb_mcp4922_rx
// Brief    : Self-checking bench for mcp4922_rx (vector table plus scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcp4922_rx;

  localparam int SS = 2;
  localparam int PH = SS + 1;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        cs_n   = 1'b1;
  logic        sck    = 1'b0;
  logic        sdi    = 1'b0;
  logic        ldac_n = 1'b0;
  logic [11:0] out_a;
  logic [11:0] out_b;
  logic        shdn_n_a;
  logic        shdn_n_b;
  logic        gain1x_a;
  logic        gain1x_b;
  logic        frame_valid;
  logic        frame_axis;
  logic        frame_error;

  always #5 clk = ~clk;

  mcp4922_rx #(.SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .sck         (sck),
    .sdi         (sdi),
    .ldac_n      (ldac_n),
    .out_a       (out_a),
    .out_b       (out_b),
    .shdn_n_a    (shdn_n_a),
    .shdn_n_b    (shdn_n_b),
    .gain1x_a    (gain1x_a),
    .gain1x_b    (gain1x_b),
    .frame_valid (frame_valid),
    .frame_axis  (frame_axis),
    .frame_error (frame_error)
  );

  typedef struct {
    logic        axis;
    logic [11:0] data;
    logic        shdn;
    logic        ga;
    bit          check_out;
  } sb_t;

  typedef struct {
    logic [15:0] w;
    int          n;
    logic [27:0] exp;
  } vec_t;

  sb_t sb[$];
  int  n_total      = 0;
  int  n_pass       = 0;
  int  n_valid_seen = 0;
  int  n_err_seen   = 0;
  int  n_err_exp    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [27:0] outs();
    return {out_a, shdn_n_a, gain1x_a, out_b, shdn_n_b, gain1x_b};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = (i < 16) ? w[i] : 1'b1;
      tick(PH);
      sck = 1'b1;
      tick(PH);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] w, input int n, input bit co);
    sb_t e;
    if (n == 16) begin
      e.axis = w[15]; e.data = w[11:0]; e.shdn = w[12]; e.ga = w[13]; e.check_out = co;
      sb.push_back(e);
    end else begin
      n_err_exp++;
    end
    cs_n = 1'b0;
    tick(PH);
    shift_bits(w, n);
    tick(PH);
    cs_n = 1'b1;
    tick(PH);
  endtask

  // Scoreboard: each accepted frame is matched against the oldest pushed entry.
  always @(negedge clk) begin : mon
    sb_t e;
    if (frame_valid) begin
      n_valid_seen++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_valid: got frame_valid=1, required no pending frame");
      end else begin
        e = sb.pop_front();
        chk("frame_axis", 32'(frame_axis), 32'(e.axis));
        if (e.check_out) begin
          @(negedge clk);
          chk("out_one_cycle_after", e.axis ? 32'({out_b, shdn_n_b, gain1x_b}) : 32'({out_a, shdn_n_a, gain1x_a}),
              32'({e.data, e.shdn, e.ga}));
        end
      end
    end
  end

  logic prev_v = 1'b0;
  logic prev_e = 1'b0;
  always @(negedge clk) begin
    if (frame_valid) chk("valid_pulse_width", 32'(prev_v), 32'd0);
    if (frame_error) begin
      n_err_seen++;
      chk("error_pulse_width", 32'(prev_e), 32'd0);
    end
    prev_v = frame_valid;
    prev_e = frame_error;
  end

  initial begin
    vec_t tbl[7];
    int   v0;
    int   e0;
    logic [15:0] w;

    tbl[0] = '{16'h3ABC, 16, {12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}};
    tbl[1] = '{16'h1234, 15, {12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}};
    tbl[2] = '{16'h0FFF, 17, {12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}};
    tbl[3] = '{16'h1FFF, 16, {12'hFFF, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0}};
    tbl[4] = '{16'hB123, 16, {12'hFFF, 1'b1, 1'b0, 12'h123, 1'b1, 1'b1}};
    tbl[5] = '{16'hC555, 16, {12'hFFF, 1'b1, 1'b0, 12'h555, 1'b0, 1'b0}};
    tbl[6] = '{16'h7000, 16, {12'h000, 1'b1, 1'b1, 12'h555, 1'b0, 1'b0}};

    reset = 1'b0;
    tick(5);
    chk("reset_outputs", 32'(outs()), 32'd0);
    chk("reset_pulses", 32'({frame_valid, frame_error, frame_axis}), 32'd0);
    reset = 1'b1;
    tick(PH + 2);

    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].w, tbl[i].n, 1'b1);
      tick(6);
      chk($sformatf("vec%0d_outputs", i), 32'(outs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_errors", i), 32'(n_err_seen), 32'(n_err_exp));
    end
    chk("table_sb_drained", 32'(sb.size()), 32'd0);

    // sck activity with cs_n high must not be decoded
    v0 = n_valid_seen;
    for (int i = 0; i < 10; i++) begin
      sdi = 1'($urandom);
      tick(PH);
      sck = 1'b1;
      tick(PH);
      sck = 1'b0;
    end
    frame(16'h1FFF, 16, 1'b1);
    tick(6);
    chk("idle_sck_outputs", 32'(outs()), 32'({12'hFFF, 1'b1, 1'b0, 12'h555, 1'b0, 1'b0}));
    chk("idle_sck_valids", 32'(n_valid_seen - v0), 32'd1);
    chk("idle_sck_errors", 32'(n_err_seen), 32'(n_err_exp));

    // reset in the middle of a frame, released while cs_n still low
    v0 = n_valid_seen;
    e0 = n_err_seen;
    cs_n = 1'b0;
    tick(PH);
    shift_bits(16'h00A5, 8);
    reset = 1'b0;
    tick(3);
    chk("midreset_outputs", 32'(outs()), 32'd0);
    reset = 1'b1;
    tick(PH);
    shift_bits(16'h00FF, 8);
    tick(PH);
    cs_n = 1'b1;
    tick(8);
    chk("midreset_after_rise", 32'(outs()), 32'd0);
    chk("midreset_no_valid", 32'(n_valid_seen - v0), 32'd0);
    chk("midreset_no_error", 32'(n_err_seen - e0), 32'd0);
    frame(16'h3ABC, 16, 1'b1);
    tick(6);
    chk("post_reset_frame", 32'(outs()), 32'({12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}));

    ldac_n = 1'b1;
    tick(PH + 2);
`ifdef MCP4922_RX_LDAC_EN
    frame(16'hB123, 16, 1'b0);
    tick(6);
    chk("ldac_high_hold", 32'(outs()), 32'({12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}));
    ldac_n = 1'b0;
    tick(2);
    ldac_n = 1'b1;
    tick(6);
    chk("ldac_pulse_update", 32'(outs()), 32'({12'hABC, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1}));
`else
    frame(16'hB123, 16, 1'b1);
    tick(6);
    chk("ldac_ignored_update", 32'(outs()), 32'({12'hABC, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1}));
`endif
    ldac_n = 1'b0;
    tick(PH + 2);

    // back-to-back frames at minimum legal timing
    v0 = n_valid_seen;
    e0 = n_err_seen;
    for (int k = 0; k < 256; k++) begin
      w = {k[0], 3'b011, 12'(k)};
      frame(w, 16, 1'b1);
    end
    tick(8);
    chk("b2b_valid_count", 32'(n_valid_seen - v0), 32'd256);
    chk("b2b_no_error", 32'(n_err_seen - e0), 32'd0);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);
    chk("b2b_final_outputs", 32'(outs()), 32'({12'd254, 1'b1, 1'b1, 12'd255, 1'b1, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
